ats21_req_decoder: RTL

Client-side request front-end of the ATS21 timer core. Captures the two-beat (2 × 16-bit) instruction pair presented on ctrlA/ctrlB when the client interface asserts req, decodes both 32-bit instructions into field-level commands, and queues them in a small command FIFO. The ATS21 execution logic drains the FIFO through a valid/ready handshake. Client A's command is always ordered before client B's.

---
 rtl/ats21_req_decoder.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ats21_req_decoder.sv
// ats21_req_decoder: ATS21 client request front-end.
// Captures a two-beat A/B instruction pair, decodes each instruction into a
// field-level command and queues them (A before B) in a first-word-fall-through
// command FIFO drained by the execution core via cmd_valid/cmd_ready.
// Optional feature macro: ATS21_DEC_STATS_EN adds saturating accept/drop counters.

package ats21_req_decoder_pkg;

    // Decoded command as stored in the FIFO.
    typedef struct packed {
        logic        client;
        logic [2:0]  op;
        logic [4:0]  id;
        logic [3:0]  clock;
        logic [1:0]  rate;
        logic        flag;
        logic [3:0]  perm;
        logic [15:0] value;
    } cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } state_e;

endpackage

module ats21_req_decoder
    import ats21_req_decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] ctrlA,
    input  logic [15:0] ctrlB,
    output logic        ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_client,
    output logic [2:0]  cmd_op,
    output logic [4:0]  cmd_id,
    output logic [3:0]  cmd_clock,
    output logic [1:0]  cmd_rate,
    output logic        cmd_flag,
    output logic [3:0]  cmd_perm,
    output logic [15:0] cmd_value,
`ifdef ATS21_DEC_STATS_EN
    output logic [15:0] stat_accepted,
    output logic [15:0] stat_dropped,
`endif
    output logic        err_illegal,
    output logic        err_overrun
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            err_ill_q, err_ill_d;
    logic            err_ovr_q, err_ovr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    cmd_t            pend_q [2];
    cmd_t            pend_d [2];
    cmd_t            mem_q [FIFO_DEPTH];

    logic [15:0]     beat_w [2];
    cmd_t            dec_hi [2];
    cmd_t            beat_cmd [2];
    logic [1:0]      push;
    logic [1:0]      illegal;
    logic            pop;
    cmd_t            head;

    assign beat_w[0] = ctrlA;
    assign beat_w[1] = ctrlB;

    // Per-client decode: high-word fields at capture, value word and push/illegal in BEAT2.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dec_hi[c]        = '0;
            dec_hi[c].client = 1'(c);
            dec_hi[c].op     = beat_w[c][15:13];
            case (beat_w[c][15:13])
                3'b001: begin
                    dec_hi[c].clock = beat_w[c][12:9];
                    dec_hi[c].rate  = beat_w[c][7:6];
                end
                3'b010: begin
                    dec_hi[c].clock = beat_w[c][12:9];
                    dec_hi[c].flag  = beat_w[c][7];
                end
                3'b011: begin
                    dec_hi[c].flag  = beat_w[c][12];
                    dec_hi[c].perm  = beat_w[c][11:8];
                end
                3'b101: begin
                    dec_hi[c].id    = beat_w[c][12:8];
                    dec_hi[c].clock = beat_w[c][3:0];
                    dec_hi[c].flag  = beat_w[c][7];
                end
                3'b110: begin
                    dec_hi[c].id    = beat_w[c][12:8];
                    dec_hi[c].clock = beat_w[c][3:0];
                end
                3'b111: begin
                    dec_hi[c].id    = beat_w[c][12:8];
                    dec_hi[c].flag  = beat_w[c][7];
                end
                default: begin
                end
            endcase

            beat_cmd[c] = pend_q[c];
            if ((pend_q[c].op == 3'b101) || (pend_q[c].op == 3'b110)) begin
                beat_cmd[c].value = beat_w[c];
            end
            push[c]    = (state_q == ST_BEAT2) && (pend_q[c].op != 3'b000)
                                               && (pend_q[c].op != 3'b100);
            illegal[c] = (state_q == ST_BEAT2) && (pend_q[c].op == 3'b100);
        end
    end

    // Capture FSM next state, FIFO bookkeeping and registered-output next values.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        err_ovr_d = 1'b0;
        err_ill_d = |illegal;
        pop       = valid_q & cmd_ready;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (ready_q) begin
                        pend_d  = dec_hi;
                        state_d = ST_BEAT2;
                    end else begin
                        err_ovr_d = 1'b1;
                    end
                end
            end
            ST_BEAT2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_d  = count_q + CW'(push[0]) + CW'(push[1]) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push[0]) + PW'(push[1]);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        valid_d  = (count_d != '0);
        // Two free slots are required so the following BEAT2 push can never overflow.
        ready_d  = (state_d == ST_IDLE) && (count_d <= CW'(FIFO_DEPTH - 2));
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_ill_q <= 1'b0;
            err_ovr_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            err_ill_q <= err_ill_d;
            err_ovr_q <= err_ovr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
        end
    end

    // FIFO storage; A lands at the write pointer, B right behind it.
    always_ff @(posedge clk) begin
        if (push[0]) begin
            mem_q[wr_ptr_q] <= beat_cmd[0];
        end
        if (push[1]) begin
            mem_q[wr_ptr_q + PW'(push[0])] <= beat_cmd[1];
        end
    end

    assign head        = valid_q ? mem_q[rd_ptr_q] : '0;
    assign ready       = ready_q;
    assign cmd_valid   = valid_q;
    assign cmd_client  = head.client;
    assign cmd_op      = head.op;
    assign cmd_id      = head.id;
    assign cmd_clock   = head.clock;
    assign cmd_rate    = head.rate;
    assign cmd_flag    = head.flag;
    assign cmd_perm    = head.perm;
    assign cmd_value   = head.value;
    assign err_illegal = err_ill_q;
    assign err_overrun = err_ovr_q;

`ifdef ATS21_DEC_STATS_EN
    logic [15:0] stat_acc_q, stat_acc_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [16:0] acc_sum;
    logic [16:0] drop_sum;

    // Saturating accepted/dropped counter next values.
    always_comb begin
        acc_sum     = {1'b0, stat_acc_q} + 17'(push[0]) + 17'(push[1]);
        drop_sum    = {1'b0, stat_drop_q} + 17'(err_ovr_d) + 17'(illegal[0]) + 17'(illegal[1]);
        stat_acc_d  = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        stat_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_acc_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_acc_q  <= stat_acc_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_accepted = stat_acc_q;
    assign stat_dropped  = stat_drop_q;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule
